// File: rtl/vga_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants and the packed-pixel unpack helper.
// The sys_clk write stage also uses these constants.
package vga_scanout_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_REAL_COLOR_SIZE = 10;
    localparam int CNT_W               = 10;
    localparam int FRAME_CNT_W         = 16;

    typedef struct packed {
        logic [VGA_REAL_COLOR_SIZE-1:0] r;
        logic [VGA_REAL_COLOR_SIZE-1:0] g;
        logic [VGA_REAL_COLOR_SIZE-1:0] b;
    } pixel_t;

    // Green is split across the two read ports: high half rides with red, low half with blue.
    function automatic pixel_t unpack_pixel(input logic [14:0] w1, input logic [14:0] w2);
        pixel_t px;
        px.r = w1[9:0];
        px.g = {w1[14:10], w2[14:10]};
        px.b = w2[9:0];
        return px;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Read-side bus between the frame-buffer read FIFOs and the VGA scan-out pipeline.
interface vga_scanout_if;

    logic [15:0] rd_word_1;
    logic [15:0] rd_word_2;
    logic        rd_empty_1;
    logic        rd_empty_2;
    logic        rd_req;
    logic        rd_load;

    modport master (
        input  rd_word_1,
        input  rd_word_2,
        input  rd_empty_1,
        input  rd_empty_2,
        output rd_req,
        output rd_load
    );

    modport slave (
        output rd_word_1,
        output rd_word_2,
        output rd_empty_1,
        output rd_empty_2,
        input  rd_req,
        input  rd_load
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters plus the stage-0 decode of sync, active area
// and the frame-buffer reload point.
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_active,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_load_pt,
    output logic             o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_enable) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Stage 0 decode
    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_hsync_n   = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
    assign o_vsync_n   = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    assign o_load_pt   = (r_h_cnt == '0) && (r_v_cnt == V_ACT);
    assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: issues FIFO read strobes for each visible pixel, unpacks the two
// 16-bit read words into 10-bit RGB and aligns sync/blank with the colour output.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE        = VGA_H_ACTIVE,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_ACTIVE        = VGA_V_ACTIVE,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter int REAL_COLOR_SIZE = VGA_REAL_COLOR_SIZE
) (
    input  logic                       vga_clk,
    input  logic                       reset_n,
    input  logic                       enable,
    vga_scanout_if.master              fifo,
    output logic [CNT_W-1:0]           debug_x,
    output logic [CNT_W-1:0]           debug_y,
    output logic [REAL_COLOR_SIZE-1:0] vga_r,
    output logic [REAL_COLOR_SIZE-1:0] vga_g,
    output logic [REAL_COLOR_SIZE-1:0] vga_b,
    output logic                       hsync_n,
    output logic                       vsync_n,
    output logic                       blank_n,
    output logic                       underflow,
    output logic [FRAME_CNT_W-1:0]     frame_count
);

    logic w_active;
    logic w_hsync_n;
    logic w_vsync_n;
    logic w_load_pt;
    logic w_frame_end;
    logic w_rd_empty;
    pixel_t w_pix_p2;

    logic r_rd_req_p1;
    logic r_rd_load;
    logic r_hs_p1, r_hs_p2, r_hs_p3;
    logic r_vs_p1, r_vs_p2, r_vs_p3;
    logic r_bl_p1, r_bl_p2, r_bl_p3;
    logic r_vld_p2;
    logic r_underflow;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic [REAL_COLOR_SIZE-1:0] r_r_p3, r_g_p3, r_b_p3;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk       (vga_clk),
        .i_rst_n     (reset_n),
        .i_enable    (enable),
        .o_h_cnt     (debug_x),
        .o_v_cnt     (debug_y),
        .o_active    (w_active),
        .o_hsync_n   (w_hsync_n),
        .o_vsync_n   (w_vsync_n),
        .o_load_pt   (w_load_pt),
        .o_frame_end (w_frame_end)
    );

    assign w_rd_empty = fifo.rd_empty_1 || fifo.rd_empty_2;
    assign w_pix_p2   = unpack_pixel(fifo.rd_word_1[14:0], fifo.rd_word_2[14:0]);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_rd_req_p1   <= 1'b0;
            r_rd_load     <= 1'b0;
            r_hs_p1       <= 1'b1;
            r_hs_p2       <= 1'b1;
            r_hs_p3       <= 1'b1;
            r_vs_p1       <= 1'b1;
            r_vs_p2       <= 1'b1;
            r_vs_p3       <= 1'b1;
            r_bl_p1       <= 1'b0;
            r_bl_p2       <= 1'b0;
            r_bl_p3       <= 1'b0;
            r_vld_p2      <= 1'b0;
            r_underflow   <= 1'b0;
            r_frame_count <= '0;
            r_r_p3        <= '0;
            r_g_p3        <= '0;
            r_b_p3        <= '0;
        end else begin
            // S0 -> S1: read strobe and sync terms
            r_rd_req_p1 <= w_active && enable;
            r_rd_load   <= w_load_pt && enable;
            r_hs_p1     <= w_hsync_n;
            r_vs_p1     <= w_vsync_n;
            r_bl_p1     <= w_active;

            // S1 -> S2: a strobe that hit an empty FIFO yields a black pixel
            r_vld_p2    <= r_rd_req_p1 && !w_rd_empty;
            r_underflow <= r_underflow || (r_rd_req_p1 && w_rd_empty);
            r_hs_p2     <= r_hs_p1;
            r_vs_p2     <= r_vs_p1;
            r_bl_p2     <= r_bl_p1;

            // S2 -> S3: read data is on the bus now; register the unpacked colour
            r_r_p3  <= r_vld_p2 ? w_pix_p2.r : '0;
            r_g_p3  <= r_vld_p2 ? w_pix_p2.g : '0;
            r_b_p3  <= r_vld_p2 ? w_pix_p2.b : '0;
            r_hs_p3 <= r_hs_p2;
            r_vs_p3 <= r_vs_p2;
            r_bl_p3 <= r_bl_p2;

            if (enable && w_frame_end) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    assign fifo.rd_req  = r_rd_req_p1;
    assign fifo.rd_load = r_rd_load;
    assign vga_r        = r_r_p3;
    assign vga_g        = r_g_p3;
    assign vga_b        = r_b_p3;
    assign hsync_n      = r_hs_p3;
    assign vsync_n      = r_vs_p3;
    assign blank_n      = r_bl_p3;
    assign underflow    = r_underflow;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken raster (32x15) so full frames stay short.
module tb_vga_scanout;

    localparam int HA = 20, HFP = 3, HS = 5, HBP = 4;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int F  = HT * VT;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [9:0]  debug_x, debug_y;
    logic [9:0]  vga_r, vga_g, vga_b;
    logic        hsync_n, vsync_n, blank_n, underflow;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;

    vga_scanout_if fifo_if ();

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .REAL_COLOR_SIZE (10)
    ) dut (
        .vga_clk     (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .fifo        (fifo_if),
        .debug_x     (debug_x),
        .debug_y     (debug_y),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .blank_n     (blank_n),
        .underflow   (underflow),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_xy(input int x, input int y, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (debug_x == 10'(x) && debug_y == 10'(y)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [15:0] pat_w1 [3];
    logic [15:0] pat_w2 [3];
    logic [9:0]  pat_r  [3];
    logic [9:0]  pat_g  [3];
    logic [9:0]  pat_b  [3];

    initial begin
        bit ok;
        int first_blank, first_hs, first_vs, first_load;
        int n_req, n_load, n_overlap, hs_low, bad_cnt, bad_sync, bad_pix;
        int eh, ev, p, ph, pv;
        logic ehs, evs, ebl;

        pat_w1[0] = 16'h1234; pat_w2[0] = 16'h4321;
        pat_r[0]  = 10'h234;  pat_g[0]  = 10'h090;  pat_b[0] = 10'h321;
        pat_w1[1] = 16'hFC00; pat_w2[1] = 16'h83FF;
        pat_r[1]  = 10'h000;  pat_g[1]  = 10'h3E0;  pat_b[1] = 10'h3FF;
        pat_w1[2] = 16'h8000; pat_w2[2] = 16'h7C00;
        pat_r[2]  = 10'h000;  pat_g[2]  = 10'h01F;  pat_b[2] = 10'h000;

        reset_n = 1'b0;
        enable  = 1'b0;
        fifo_if.rd_word_1  = 16'h7FFF;
        fifo_if.rd_word_2  = 16'h0000;
        fifo_if.rd_empty_1 = 1'b0;
        fifo_if.rd_empty_2 = 1'b0;
        step(3);

        chk("rst_h", 32'(debug_x), 0);
        chk("rst_v", 32'(debug_y), 0);
        chk("rst_hsync", 32'(hsync_n), 1);
        chk("rst_vsync", 32'(vsync_n), 1);
        chk("rst_blank", 32'(blank_n), 0);
        chk("rst_rgb", {2'b0, vga_r, vga_g, vga_b}, 0);
        chk("rst_rdreq", 32'(fifo_if.rd_req), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_frames", 32'(frame_count), 0);

        // Two full frames from reset release
        reset_n = 1'b1;
        enable  = 1'b1;
        first_blank = -1; first_hs = -1; first_vs = -1; first_load = -1;
        n_req = 0; n_load = 0; n_overlap = 0; hs_low = 0;
        bad_cnt = 0; bad_sync = 0; bad_pix = 0;
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk);
            eh = (i + 1) % HT;
            ev = ((i + 1) / HT) % VT;
            if (debug_x != 10'(eh) || debug_y != 10'(ev)) bad_cnt++;
            p = i - 2;
            if (p < 0) begin
                ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
            end else begin
                ph  = p % HT;
                pv  = (p / HT) % VT;
                ehs = !(ph >= HA + HFP && ph < HA + HFP + HS);
                evs = !(pv >= VA + VFP && pv < VA + VFP + VS);
                ebl = (ph < HA) && (pv < VA);
            end
            if (hsync_n !== ehs || vsync_n !== evs || blank_n !== ebl) bad_sync++;
            if (blank_n) begin
                if ({vga_r, vga_g, vga_b} !== {10'h3FF, 10'h3E0, 10'h000}) bad_pix++;
            end else if ({vga_r, vga_g, vga_b} !== 30'd0) begin
                bad_pix++;
            end
            if (blank_n && first_blank < 0) first_blank = i;
            if (!hsync_n && first_hs < 0) first_hs = i;
            if (!vsync_n && first_vs < 0) first_vs = i;
            if (p >= 0 && p < F && !hsync_n) hs_low++;
            if (i < F && fifo_if.rd_req) n_req++;
            if (fifo_if.rd_load) begin
                n_load++;
                if (first_load < 0) first_load = i;
                if (fifo_if.rd_req) n_overlap++;
            end
        end
        chk("counter_seq", 32'(bad_cnt), 0);
        chk("sync_seq", 32'(bad_sync), 0);
        chk("pixel_seq", 32'(bad_pix), 0);
        chk("blank_latency", 32'(first_blank), 2);
        chk("hsync_first", 32'(first_hs), 32'(HA + HFP + 2));
        chk("vsync_first", 32'(first_vs), 32'((VA + VFP) * HT + 2));
        chk("hsync_low_per_frame", 32'(hs_low), 32'(HS * VT));
        chk("rdreq_per_frame", 32'(n_req), 32'(HA * VA));
        chk("rdload_count", 32'(n_load), 2);
        chk("rdload_pos", 32'(first_load), 32'(VA * HT));
        chk("rdload_overlap", 32'(n_overlap), 0);
        chk("frames_2", 32'(frame_count), 2);

        // Unpack patterns, one per line
        for (int k = 0; k < 3; k++) begin
            fifo_if.rd_word_1 = pat_w1[k];
            fifo_if.rd_word_2 = pat_w2[k];
            wait_xy(5, k + 1, 2 * F, ok);
            chk("pat_wait", 32'(ok), 1);
            step(3);
            chk("pat_blank", 32'(blank_n), 1);
            chk("pat_r", 32'(vga_r), 32'(pat_r[k]));
            chk("pat_g", 32'(vga_g), 32'(pat_g[k]));
            chk("pat_b", 32'(vga_b), 32'(pat_b[k]));
        end
        fifo_if.rd_word_1 = 16'h7FFF;
        fifo_if.rd_word_2 = 16'h0000;

        // Underflow on a single strobe mid-line
        wait_xy(6, 4, 2 * F, ok);
        chk("uf_wait", 32'(ok), 1);
        chk("uf_rdreq", 32'(fifo_if.rd_req), 1);
        fifo_if.rd_empty_2 = 1'b1;
        step(1);
        fifo_if.rd_empty_2 = 1'b0;
        chk("uf_set", 32'(underflow), 1);
        step(1);
        chk("uf_timing", 32'(debug_x), 8);
        chk("uf_blank", 32'(blank_n), 1);
        chk("uf_black", {2'b0, vga_r, vga_g, vga_b}, 0);
        step(1);
        chk("uf_next_r", 32'(vga_r), 32'h3FF);
        step(100);
        chk("uf_sticky", 32'(underflow), 1);

        // Enable hold mid-line
        wait_xy(10, 6, 2 * F, ok);
        chk("hold_wait", 32'(ok), 1);
        enable = 1'b0;
        n_req = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fifo_if.rd_req) n_req++;
        end
        chk("hold_h", 32'(debug_x), 10);
        chk("hold_v", 32'(debug_y), 6);
        chk("hold_rdreq", 32'(n_req), 0);
        enable = 1'b1;
        step(1);
        chk("resume_h", 32'(debug_x), 11);
        chk("resume_rdreq", 32'(fifo_if.rd_req), 1);

        // Reset mid-frame
        wait_xy(15, 5, 2 * F, ok);
        chk("rst2_wait", 32'(ok), 1);
        reset_n = 1'b0;
        step(1);
        chk("rst2_h", 32'(debug_x), 0);
        chk("rst2_v", 32'(debug_y), 0);
        chk("rst2_underflow", 32'(underflow), 0);
        chk("rst2_frames", 32'(frame_count), 0);
        chk("rst2_rgb", {2'b0, vga_r, vga_g, vga_b}, 0);
        chk("rst2_blank", 32'(blank_n), 0);
        reset_n = 1'b1;
        first_load = -1;
        n_load = 0;
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            if (fifo_if.rd_load) begin
                n_load++;
                if (first_load < 0) first_load = i;
            end
        end
        chk("rst2_rdload_pos", 32'(first_load), 32'(VA * HT));
        chk("rst2_rdload_count", 32'(n_load), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks.
- V_ACTIVE, 480, visible lines.
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines.
- REAL_COLOR_SIZE, 10, bits per colour channel.
REQ-002 Ports (name, direction, width, meaning), one per line:
- vga_clk, in, 1, sole clock.
- reset_n, in, 1, reset.
- enable, in, 1, scan-out run enable; SDRAM init is done.
- rd_word_1, in, 16, read-port-1 data: {x, g[9:5], r[9:0]}.
- rd_word_2, in, 16, read-port-2 data: {x, g[4:0], b[9:0]}.
- rd_empty_1 / rd_empty_2, in, 1 each, read FIFO empty flags.
- rd_req, out, 1, read strobe driven to both read ports.
- rd_load, out, 1, one-cycle FIFO address reload pulse.
- debug_x / debug_y, out, 10 each, raw counters h_cnt / v_cnt.
- vga_r / vga_g / vga_b, out, 10 each, pixel colour.
- hsync_n / vsync_n / blank_n, out, 1 each, active-low sync and blank.
- underflow, out, 1, sticky underflow flag.
- frame_count, out, 16, completed-frame count.
REQ-003 Decided: one clock vga_clk; reset_n is synchronous and active-low.

Function
REQ-004 h_cnt counts 0..H_TOTAL-1 (H_TOTAL=800) while enable=1; wraps to 0. v_cnt increments at each h_cnt wrap, counts 0..V_TOTAL-1 (525), then wraps to 0.
REQ-005 enable=0 holds both counters. rd_req and rd_load are forced 0. Pipeline outputs continue to drain.
REQ-006 Stage S0 = counters. active0 = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
REQ-007 rd_req is registered: rd_req(t+1) = active0(t) && enable(t). Exactly 640 strobes per line, 307200 per frame.
REQ-008 Read data is valid the cycle after rd_req (S2). Unpack at S2 and register into vga_* at S3:
- r = rd_word_1[9:0]
- g = {rd_word_1[14:10], rd_word_2[14:10]}
- b = rd_word_2[9:0]
REQ-009 Sync terms computed at S0:
- hsync_n = 0 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync_n = 0 for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- blank_n = active0.
All three are delayed 3 clocks so they align with vga_*.
REQ-010 When blank_n=0 at the output, vga_r/g/b SHALL be 0.
REQ-011 Underflow: if rd_req=1 while rd_empty_1 or rd_empty_2 is 1, then underflow sets and stays 1 until reset. That pixel outputs 0/0/0; the counters are not stalled.
REQ-012 rd_load pulses for one cycle at the clock after (h_cnt==0 && v_cnt==V_ACTIVE), i.e. once per frame, in vertical blank, never concurrent with rd_req.
REQ-013 frame_count increments by 1 (wrapping at 2^16) when v_cnt wraps 524->0.
REQ-014 debug_x/debug_y equal h_cnt/v_cnt combinationally, full range 0..799 / 0..524.

Reset
REQ-015 With reset_n=0 at a vga_clk edge, all of the following clear on that edge:
- h_cnt, v_cnt, rd_req, rd_load, vga_r/g/b, underflow, frame_count, all pipeline registers.
- hsync_n=1, vsync_n=1, blank_n=0.
REQ-016 Reset mid-line or mid-frame restarts at (0,0). The first rd_load occurs in the following vertical blank.

Structure
REQ-017 A shared package holds the VGA timing constants (H/V active, porch, sync, totals) and REAL_COLOR_SIZE, for reuse by the sys_clk write stage.
REQ-018 One sub-module, vga_timing_gen, SHALL own the counters and the S0 sync/active decode. vga_scanout owns the read pipeline, unpack, underflow and frame logic.

Verification
REQ-019 Reset, then enable=1 with FIFOs non-empty, for 2 frames -> 800 clocks per line, 525 lines per frame; hsync_n low 96 clocks starting at h=656; vsync_n low lines 490-491; frame_count=2.
REQ-020 rd_word_1=16'h7FFF, rd_word_2=16'h0000 -> in active area vga_r=10'h3FF, vga_g=10'h3E0, vga_b=0; 3-clock latency from h_cnt=0 to the first blank_n=1.
REQ-021 Count rd_req over one frame -> exactly 307200. rd_load is seen exactly once, one clock after (h=0, v=480).
REQ-022 Assert rd_empty_2=1 for 1 clock during an active rd_req -> underflow=1 permanently, that pixel 0/0/0, timing unchanged.
REQ-023 Drop enable=0 at (h=300, v=100) for 50 clocks -> counters hold at (300,100), no rd_req; resume continues from 300.
REQ-024 Assert reset_n=0 at (h=400, v=200) -> the next clock shows h=0, v=0, underflow=0, frame_count=0, vga_*=0.
